// File: rtl/seven_seg_if.sv
// Scan controller bus: digit register write port plus multiplexed display outputs.
interface seven_seg_if;
  logic       i_en;
  logic       i_wr_en;
  logic [1:0] i_wr_addr;
  logic [4:0] i_wr_data;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [3:0] o_dig;
  logic       o_frame;

  modport master (
    output i_en, i_wr_en, i_wr_addr, i_wr_data,
    input  o_seg, o_dp, o_dig, o_frame
  );

  modport slave (
    input  i_en, i_wr_en, i_wr_addr, i_wr_data,
    output o_seg, o_dp, o_dig, o_frame
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with blanking gaps between digits.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 4000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  seven_seg_if.slave bus
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_DRIVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [4:0]       shadow_q, shadow_d;
  logic [3:0][4:0]  regs_q, regs_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_q, dig_d;
  logic             frame_q, frame_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b0111111;
      4'h1: hex_to_seg = 7'b0000110;
      4'h2: hex_to_seg = 7'b1011011;
      4'h3: hex_to_seg = 7'b1001111;
      4'h4: hex_to_seg = 7'b1100110;
      4'h5: hex_to_seg = 7'b1101101;
      4'h6: hex_to_seg = 7'b1111101;
      4'h7: hex_to_seg = 7'b0000111;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1101111;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b1111100;
      4'hC: hex_to_seg = 7'b0111001;
      4'hD: hex_to_seg = 7'b1011110;
      4'hE: hex_to_seg = 7'b1111001;
      default: hex_to_seg = 7'b1110001;
    endcase
  endfunction

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic lz_q, lz_d;
  logic lz_hit_c;

  // A zero digit goes dark only when every higher digit is also zero; digit 0 never blanks.
  always_comb begin
    lz_hit_c = (idx_q != 2'd0) && (regs_q[idx_q] == 5'd0);
    for (int i = 1; i < 4; i++) begin
      if ((i > int'(idx_q)) && (regs_q[2'(i)] != 5'd0)) lz_hit_c = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    dig_d    = dig_q;
    frame_d  = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    lz_d     = lz_q;
`endif

    if (bus.i_wr_en) regs_d[bus.i_wr_addr] = bus.i_wr_data;

    if (!bus.i_en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = 2'd0;
      seg_d   = '0;
      dp_d    = 1'b0;
      dig_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
          seg_d   = '0;
          dp_d    = 1'b0;
          dig_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            // Snapshot the digit so writes during its dwell cannot glitch the display.
            state_d  = ST_DRIVE;
            cnt_d    = DWELL_LOAD;
            shadow_d = regs_q[idx_q];
            seg_d    = hex_to_seg(regs_q[idx_q][3:0]);
            dp_d     = regs_q[idx_q][4];
            dig_d    = 4'b0001 << idx_q;
`ifdef SEVEN_SEG_LZ_BLANK_EN
            lz_d     = lz_hit_c;
            if (lz_hit_c) seg_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            idx_d   = idx_q + 2'd1;
            frame_d = (idx_q == 2'd3);
            seg_d   = '0;
            dp_d    = 1'b0;
            dig_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            seg_d = hex_to_seg(shadow_q[3:0]);
            dp_d  = shadow_q[4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
            if (lz_q) seg_d = '0;
`endif
          end
        end
        default: begin
          state_d = ST_OFF;
          seg_d   = '0;
          dp_d    = 1'b0;
          dig_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      regs_q   <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      dig_q    <= '0;
      frame_q  <= 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      lz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      lz_q     <= lz_d;
`endif
    end
  end

  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_dig   = dig_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DWELL_CYCLES=8, BLANK_CYCLES=2 (40-cycle frame).
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_checks = 0;
  logic [4:0] mdl_reg [4];

  always #5 clk = ~clk;

  seven_seg_if bus ();

  seven_seg_scan_ctrl #(
    .DWELL_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Standard a-g patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'h3F; 4'h1: seg_of = 7'h06; 4'h2: seg_of = 7'h5B; 4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66; 4'h5: seg_of = 7'h6D; 4'h6: seg_of = 7'h7D; 4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F; 4'h9: seg_of = 7'h6F; 4'hA: seg_of = 7'h77; 4'hB: seg_of = 7'h7C;
      4'hC: seg_of = 7'h39; 4'hD: seg_of = 7'h5E; 4'hE: seg_of = 7'h79; default: seg_of = 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    logic [4:0] v;
    v = mdl_reg[d];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (d != 0 && v == 5'd0) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = d + 1; j < 4; j++) if (mdl_reg[j] != 5'd0) all_zero = 1'b0;
      if (all_zero) return 7'h00;
    end
`endif
    return seg_of(v[3:0]);
  endfunction

  task automatic check_dark(input string tag);
    check({tag, " dig"}, 32'(bus.o_dig), 32'h0);
    check({tag, " seg"}, 32'(bus.o_seg), 32'h0);
    check({tag, " dp"}, 32'(bus.o_dp), 32'h0);
    check({tag, " frame"}, 32'(bus.o_frame), 32'h0);
  endtask

  // Cycle k after enable: each digit is 2 dark + 8 lit, frame pulse on the first cycle of each new frame.
  task automatic run_scan(input int ncyc, input int wr_at, input logic [1:0] wa, input logic [4:0] wd);
    logic [6:0] sh_seg [4];
    logic       sh_dp  [4];
    int p, d, w;
    logic lit;
    for (int i = 0; i < 4; i++) begin sh_seg[i] = 7'h00; sh_dp[i] = 1'b0; end
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      p = (k - 1) % 40;
      d = p / 10;
      w = p % 10;
      lit = (w >= 2);
      if (w == 2) begin
        sh_seg[d] = exp_seg(d);
        sh_dp[d]  = mdl_reg[d][4];
      end
      check($sformatf("dig k=%0d", k), 32'(bus.o_dig), lit ? 32'(4'b0001 << d) : 32'h0);
      check($sformatf("seg k=%0d", k), 32'(bus.o_seg), lit ? 32'(sh_seg[d]) : 32'h0);
      check($sformatf("dp k=%0d", k), 32'(bus.o_dp), lit ? 32'(sh_dp[d]) : 32'h0);
      check($sformatf("frame k=%0d", k), 32'(bus.o_frame), (k > 1 && p == 0) ? 32'h1 : 32'h0);
      if (k == wr_at) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = wa;
        bus.i_wr_data = wd;
        mdl_reg[wa]   = wd;
      end
      if (k == wr_at + 1) bus.i_wr_en = 1'b0;
    end
  endtask

  task automatic write_all(input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] d3);
    logic [4:0] vals [4];
    vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
    for (int i = 0; i < 4; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = 2'(i);
      bus.i_wr_data = vals[i];
      mdl_reg[i]    = vals[i];
      @(negedge clk);
    end
    bus.i_wr_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_en      = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_addr = 2'd0;
    bus.i_wr_data = 5'd0;
    for (int i = 0; i < 4; i++) mdl_reg[i] = 5'd0;

    repeat (2) @(negedge clk);
    check_dark("reset");
    rst = 1'b0;

    // Digits 1,2,3,4 written while disabled; display stays dark.
    write_all(5'h01, 5'h02, 5'h03, 5'h04);
    check_dark("disabled");

    // Full scan plus a mid-dwell write to digit 1 that must only show on its next visit.
    bus.i_en = 1'b1;
    run_scan(104, 15, 2'd1, 5'h1A);

    // Cycle 104 is mid-dwell of digit 2; dropping enable darkens the next cycle.
    bus.i_en = 1'b0;
    @(negedge clk);
    check_dark("en drop");
    @(negedge clk);
    check_dark("en low");

    // Re-enable restarts at digit 0 after two dark cycles; stop during digit 3 dwell.
    bus.i_en = 1'b1;
    run_scan(33, 0, 2'd0, 5'd0);
    check("pre-reset dig", 32'(bus.o_dig), 32'h8);

    // Asynchronous reset clears outputs without waiting for a clock edge.
    rst = 1'b1;
    #1;
    check_dark("async rst");
    for (int i = 0; i < 4; i++) mdl_reg[i] = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_scan(42, 0, 2'd0, 5'd0);

`ifdef SEVEN_SEG_LZ_BLANK_EN
    bus.i_en = 1'b0;
    write_all(5'h00, 5'h07, 5'h00, 5'h00);
    bus.i_en = 1'b1;
    run_scan(40, 0, 2'd0, 5'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
